// File: rtl/countdown_ctrl_pkg.sv
// Shared definitions for the countdown timer: state encoding (also used by the
// timer register decode), default count width and prescaler sizing.
package countdown_ctrl_pkg;

    localparam int CNT_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_COUNT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Prescaler counter width: max(1, clog2(presc))
    function automatic int presc_width(input int presc);
        return (presc <= 2) ? 1 : $clog2(presc);
    endfunction

endpackage

// File: rtl/countdown_ctrl_tick.sv
// Divides CLK by PRESCALE while enabled; TICK marks the terminal count.
// CLR restarts the division so the first tick lands PRESCALE cycles after COUNT begins.
module tick_prescaler
    import countdown_ctrl_pkg::*;
#(
    parameter int PRESCALE = 1
) (
    input  logic CLK,
    input  logic RST,
    input  logic CLR,
    input  logic EN,
    output logic TICK
);

    localparam int PW = presc_width(PRESCALE);
    localparam logic [PW-1:0] TERM = PW'(PRESCALE - 1);

    logic [PW-1:0] count;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            count <= '0;
        else if (CLR)
            count <= '0;
        else if (EN)
            count <= (count == TERM) ? '0 : count + PW'(1);
    end

    assign TICK = EN && (count == TERM);

endmodule

// File: rtl/countdown_ctrl.sv
// Control stage around the external downcounter: latches N, drives LD/EN/D,
// watches Q for zero and reports BUSY, sticky DONE and a one-cycle IRQ.
module countdown_ctrl
    import countdown_ctrl_pkg::*;
#(
    parameter int WIDTH    = CNT_WIDTH,
    parameter int PRESCALE = 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             GO,
    input  logic [WIDTH-1:0] N,
    input  logic             ACK,
    input  logic             CANCEL,
    output logic             CNT_LD,
    output logic             CNT_EN,
    output logic [WIDTH-1:0] CNT_D,
    input  logic [WIDTH-1:0] CNT_Q,
    output logic             BUSY,
    output logic             DONE,
    output logic             IRQ
);

    state_t           state;
    logic [WIDTH-1:0] n_latch;
    logic             irq_flag;
    logic             tick;
    logic             q_zero;

    assign q_zero = (CNT_Q == '0);

    tick_prescaler #(.PRESCALE(PRESCALE)) u_presc (
        .CLK  (CLK),
        .RST  (RST),
        .CLR  (state == ST_LOAD),
        .EN   (state == ST_COUNT),
        .TICK (tick)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= ST_IDLE;
            n_latch  <= '0;
            irq_flag <= 1'b0;
        end else begin
            irq_flag <= 1'b0;
            if (CANCEL) begin
                state <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (GO) begin
                            state   <= ST_LOAD;
                            n_latch <= N;
                        end
                    end
                    ST_LOAD:  state <= ST_COUNT;
                    ST_COUNT: begin
                        if (q_zero) begin
                            state    <= ST_DONE;
                            irq_flag <= 1'b1;
                        end
                    end
                    ST_DONE: begin
                        // GO restarts even when ACK arrives in the same cycle
                        if (GO) begin
                            state   <= ST_LOAD;
                            n_latch <= N;
                        end else if (ACK) begin
                            state <= ST_IDLE;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    // Q is only trusted in COUNT (it is don't-care after reset); EN is
    // withheld at zero so the counter never wraps to all-ones.
    assign CNT_LD = (state == ST_LOAD);
    assign CNT_EN = (state == ST_COUNT) && !q_zero && tick;
    assign CNT_D  = n_latch;
    assign BUSY   = (state == ST_LOAD) || (state == ST_COUNT);
    assign DONE   = (state == ST_DONE);
    assign IRQ    = irq_flag;

endmodule

// File: tb/tb_countdown_ctrl.sv
// Bench: two controllers (PRESCALE 1 and 4) share stimulus, each driving its own
// downcounter model; an arithmetic timing model is compared every cycle.
module tb_countdown_ctrl;

    localparam int W  = 32;
    localparam int P0 = 1;
    localparam int P1 = 4;

    logic clk = 1'b0, rst = 1'b1, go = 1'b0, ack = 1'b0, cancel = 1'b0;
    logic [W-1:0] n = '0;
    logic ld0, en0, busy0, done0, irq0, ld1, en1, busy1, done1, irq1;
    logic [W-1:0] d0, d1;
    logic [W-1:0] q0 = 32'hDEAD_BEEF, q1 = 32'h1234_5678;

    int n_cmp = 0, n_bad = 0;
    int cyc = 0;
    bit chk_on = 1'b0;

    always #5 clk = ~clk;

    countdown_ctrl #(.WIDTH(W), .PRESCALE(P0)) dut0 (
        .CLK(clk), .RST(rst), .GO(go), .N(n), .ACK(ack), .CANCEL(cancel),
        .CNT_LD(ld0), .CNT_EN(en0), .CNT_D(d0), .CNT_Q(q0),
        .BUSY(busy0), .DONE(done0), .IRQ(irq0)
    );

    countdown_ctrl #(.WIDTH(W), .PRESCALE(P1)) dut1 (
        .CLK(clk), .RST(rst), .GO(go), .N(n), .ACK(ack), .CANCEL(cancel),
        .CNT_LD(ld1), .CNT_EN(en1), .CNT_D(d1), .CNT_Q(q1),
        .BUSY(busy1), .DONE(done1), .IRQ(irq1)
    );

    // Downcounters: no reset, LD over EN
    always @(posedge clk) if (ld0) q0 <= d0; else if (en0) q0 <= q0 - 1;
    always @(posedge clk) if (ld1) q1 <= d1; else if (en1) q1 <= q1 - 1;

    always @(posedge clk) cyc <= cyc + 1;

    // Timing model: a run accepted at edge k finishes at edge k+2+N*P
    int m_mode[2];  // 0 idle, 1 busy, 2 done
    int m_start[2], m_fin[2], m_n[2];
    bit m_irq[2];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                m_mode[i] <= 0;
                m_irq[i]  <= 1'b0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                automatic int p = (i == 0) ? P0 : P1;
                m_irq[i] <= 1'b0;
                if (cancel) m_mode[i] <= 0;
                else if ((m_mode[i] == 0 || m_mode[i] == 2) && go) begin
                    m_mode[i]  <= 1;
                    m_start[i] <= cyc;
                    m_fin[i]   <= cyc + 2 + int'(n) * p;
                    m_n[i]     <= int'(n);
                end else if (m_mode[i] == 1 && cyc == m_fin[i]) begin
                    m_mode[i] <= 2;
                    m_irq[i]  <= 1'b1;
                end else if (m_mode[i] == 2 && ack) m_mode[i] <= 0;
            end
        end
    end

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_inst(input int i, input logic ld, en, busy, done, irq,
                              input logic [W-1:0] q, d);
        int  p, e, qe;
        bit  b, exp_en;
        p = (i == 0) ? P0 : P1;
        e = cyc - 1;
        b = (m_mode[i] == 1);
        exp_en = 1'b0;
        if (b && e > m_start[i]) begin
            qe = m_n[i] - (e - m_start[i] - 1) / p;
            if (qe < 0) qe = 0;
            exp_en = (qe != 0) && ((e - m_start[i]) % p == 0);
            check($sformatf("q%0d", i), q, qe);
        end
        if (b) check($sformatf("d%0d", i), d, m_n[i]);
        check($sformatf("busy%0d", i), busy, b);
        check($sformatf("done%0d", i), done, m_mode[i] == 2);
        check($sformatf("irq%0d", i), irq, m_irq[i]);
        check($sformatf("ld%0d", i), ld, b && (e == m_start[i]));
        check($sformatf("en%0d", i), en, exp_en);
        check($sformatf("ld_en_excl%0d", i), ld && en, 0);
        check($sformatf("en_at_zero%0d", i), en && (q == '0), 0);
    endtask

    always @(negedge clk) begin
        if (chk_on && !rst) begin
            check_inst(0, ld0, en0, busy0, done0, irq0, q0, d0);
            check_inst(1, ld1, en1, busy1, done1, irq1, q1, d1);
        end
    end

    typedef struct {
        logic go, ack, cancel;
        logic [W-1:0] n;
        logic busy, done, irq, ld, en;
    } vec_t;

    function automatic vec_t mk(bit g, bit a, bit c, int nv, bit b, bit dn, bit ir, bit l, bit en);
        vec_t v;
        v.go = g; v.ack = a; v.cancel = c; v.n = W'(nv);
        v.busy = b; v.done = dn; v.irq = ir; v.ld = l; v.en = en;
        return v;
    endfunction

    task automatic cancel_all();
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
    endtask

    // Pulse GO with N, follow one instance until DONE; done_e is relative to the GO edge
    task automatic run_go(input int nval, input int which, input int budget,
                          output int done_e, output int en_cnt, output int ld_cnt, output int bad_gap);
        int k, last, p;
        logic l, e, dn;
        p = which ? P1 : P0;
        go = 1'b1; n = W'(nval); k = cyc;
        done_e = -1; en_cnt = 0; ld_cnt = 0; bad_gap = 0; last = -1;
        for (int c = 0; c < budget && done_e < 0; c++) begin
            @(negedge clk);
            go = 1'b0;
            if (which == 0) begin l = ld0; e = en0; dn = done0; end
            else            begin l = ld1; e = en1; dn = done1; end
            if (l) ld_cnt++;
            if (e) begin
                if (last >= 0 && (cyc - 1 - last) != p) bad_gap++;
                last = cyc - 1;
                en_cnt++;
            end
            if (dn) done_e = cyc - 1 - k;
        end
    endtask

    vec_t tbl[16];

    initial begin
        int de, enc, ldc, gb, seen;

        tbl[0]  = mk(1,0,0,2, 1,0,0,1,0);
        tbl[1]  = mk(0,0,0,0, 1,0,0,0,1);
        tbl[2]  = mk(0,0,0,0, 1,0,0,0,1);
        tbl[3]  = mk(0,0,0,0, 1,0,0,0,0);
        tbl[4]  = mk(0,0,0,0, 0,1,1,0,0);
        tbl[5]  = mk(0,0,0,0, 0,1,0,0,0);
        tbl[6]  = mk(0,1,0,0, 0,0,0,0,0);
        tbl[7]  = mk(1,0,1,3, 0,0,0,0,0);
        tbl[8]  = mk(1,0,0,0, 1,0,0,1,0);
        tbl[9]  = mk(0,0,0,0, 1,0,0,0,0);
        tbl[10] = mk(0,0,0,0, 0,1,1,0,0);
        tbl[11] = mk(1,1,0,1, 1,0,0,1,0);
        tbl[12] = mk(0,0,0,0, 1,0,0,0,1);
        tbl[13] = mk(0,0,0,0, 1,0,0,0,0);
        tbl[14] = mk(0,0,0,0, 0,1,1,0,0);
        tbl[15] = mk(0,0,1,0, 0,0,0,0,0);

        repeat (2) @(negedge clk);
        check("rst_busy", {busy0, busy1}, 0);
        check("rst_done", {done0, done1}, 0);
        check("rst_irq",  {irq0, irq1}, 0);
        check("rst_ld_en", {ld0, ld1, en0, en1}, 0);
        check("rst_d0", d0, 0);
        check("rst_d1", d1, 0);
        rst = 1'b0;
        chk_on = 1'b1;

        // Table on the PRESCALE=1 instance
        for (int r = 0; r < 16; r++) begin
            go = tbl[r].go; ack = tbl[r].ack; cancel = tbl[r].cancel; n = tbl[r].n;
            @(negedge clk);
            check($sformatf("tbl%0d_busy", r), busy0, tbl[r].busy);
            check($sformatf("tbl%0d_done", r), done0, tbl[r].done);
            check($sformatf("tbl%0d_irq", r),  irq0,  tbl[r].irq);
            check($sformatf("tbl%0d_ld", r),   ld0,   tbl[r].ld);
            check($sformatf("tbl%0d_en", r),   en0,   tbl[r].en);
        end
        go = 1'b0; ack = 1'b0; cancel = 1'b0;

        // N=5, PRESCALE=1
        cancel_all();
        run_go(5, 0, 40, de, enc, ldc, gb);
        check("t1_done_edge", de, 7);
        check("t1_en_count", enc, 5);
        check("t1_ld_count", ldc, 1);
        check("t1_irq", irq0, 1);
        @(negedge clk);
        check("t1_irq_drop", irq0, 0);
        check("t1_done_sticky", done0, 1);

        // N=0: no EN, no wrap
        cancel_all();
        run_go(0, 0, 20, de, enc, ldc, gb);
        check("t2_done_edge", de, 2);
        check("t2_en_count", enc, 0);
        @(negedge clk);
        check("t2_q_zero", q0, 0);

        // N=3, PRESCALE=4
        cancel_all();
        run_go(3, 1, 60, de, enc, ldc, gb);
        check("t3_done_edge", de, 14);
        check("t3_en_count", enc, 3);
        check("t3_en_gap", gb, 0);

        // Cancel in COUNT at Q=2; GO while busy ignored
        cancel_all();
        go = 1'b1; n = W'(5);
        @(negedge clk);
        go = 1'b0;
        seen = 0;
        for (int c = 0; c < 60 && !seen; c++) begin
            @(negedge clk);
            if (c == 1) begin go = 1'b1; n = W'(9); end
            else go = 1'b0;
            if (busy1 && !ld1 && q1 == W'(2)) seen = 1;
        end
        go = 1'b0;
        check("t4_reach_q2", seen, 1);
        check("t4_d_kept", d1, 5);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        check("t4_busy", busy1, 0);
        check("t4_done", done1, 0);
        check("t4_irq", irq1, 0);

        // GO+ACK together in DONE restarts
        cancel_all();
        run_go(1, 0, 20, de, enc, ldc, gb);
        check("t5_first_done", de, 3);
        go = 1'b1; ack = 1'b1; n = W'(2);
        @(negedge clk);
        go = 1'b0; ack = 1'b0;
        check("t5_busy", busy0, 1);
        check("t5_done_drop", done0, 0);
        check("t5_ld", ld0, 1);
        de = -1;
        for (int c = 1; c <= 10 && de < 0; c++) begin
            @(negedge clk);
            if (done0) de = c;
        end
        check("t5_new_done", de, 4);

        // Async reset mid-COUNT
        cancel_all();
        go = 1'b1; n = W'(6);
        @(negedge clk);
        go = 1'b0;
        repeat (3) @(negedge clk);
        check("t6_pre_en", en0, 1);
        #2 rst = 1'b1;
        #1;
        check("t6_en_async", en0, 0);
        check("t6_busy_async", {busy0, busy1}, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("t6_idle_busy", busy0, 0);
        check("t6_idle_done", done0, 0);
        run_go(1, 0, 20, de, enc, ldc, gb);
        check("t6_done_edge", de, 3);
        check("t6_en_count", enc, 1);

        // Random traffic against the model
        for (int c = 0; c < 400; c++) begin
            go     = ($urandom_range(0, 3) == 0);
            ack    = ($urandom_range(0, 5) == 0);
            cancel = ($urandom_range(0, 15) == 0);
            n      = W'($urandom_range(0, 6));
            @(negedge clk);
        end
        go = 1'b0; ack = 1'b0; cancel = 1'b0;
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
